// File: rtl/ps2_host_tx_if.sv
// Command handshake and status between the host-side controller and the PS/2 transmitter.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;

    modport master (output tx_valid, tx_data, input  tx_ready, busy, done, error);
    modport slave  (input  tx_valid, tx_data, output tx_ready, busy, done, error);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, device-clocked
// 11-bit frame with odd parity, ACK check and idle wait, all via open-drain enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic            CLK50,
    input  logic            reset,
    ps2_host_tx_if.slave    tx,
    input  logic            ps2_clk_in,
    input  logic            ps2_data_in,
    output logic            ps2_clk_oe,
    output logic            ps2_data_oe
);
    localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] REQ_LAST = 20'(REQ_CYCLES - 1);
    localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, XFER, WAITIDLE} state_t;

    state_t      state_q;
    logic [19:0] cnt_q, cnt_d;
    logic [3:0]  n_q, n_d;
    logic [7:0]  sh_q;
    logic        par_q;
    logic        clk_oe_q, data_oe_q, ready_q, busy_q, done_q, error_q;
    logic        clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
    logic        fall, txbit;
    logic [2:0]  bidx;

    // Synchronisers idle high so leaving reset never fakes a falling edge.
    always_ff @(posedge CLK50) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data_in;
            dat_s2_q   <= dat_s1_q;
        end
    end

    // Next frame bit after this fall: data LSB first, then parity, then stop.
    always_comb begin
        fall  = clk_prev_q & ~clk_s2_q;
        n_d   = n_q + 4'd1;
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 20'd1;
        bidx  = n_d[2:0] - 3'd1;
        txbit = 1'b1;
        if (n_d >= 4'd1 && n_d <= 4'd8) txbit = sh_q[bidx];
        else if (n_d == 4'd9)            txbit = par_q;
    end

    always_ff @(posedge CLK50) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            sh_q      <= '0;
            par_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx.tx_valid && ready_q) begin
                        sh_q     <= tx.tx_data;
                        par_q    <= ~^tx.tx_data;
                        n_q      <= '0;
                        cnt_q    <= '0;
                        clk_oe_q <= 1'b1;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        cnt_q     <= '0;
                        data_oe_q <= 1'b1;
                        state_q   <= REQ;
                    end else cnt_q <= cnt_d;
                end
                REQ: begin
                    if (cnt_q == REQ_LAST) begin
                        cnt_q    <= '0;
                        clk_oe_q <= 1'b0;
                        state_q  <= XFER;
                    end else cnt_q <= cnt_d;
                end
                XFER: begin
                    if (fall) begin
                        cnt_q <= '0;
                        n_q   <= n_d;
                        if (n_d == 4'd11) begin
                            data_oe_q <= 1'b0;
                            if (!dat_s2_q) state_q <= WAITIDLE;
                            else begin
                                error_q <= 1'b1;
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end else data_oe_q <= ~txbit;
                    end else if (cnt_q == TO_LAST) begin
                        error_q   <= 1'b1;
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else cnt_q <= cnt_d;
                end
                WAITIDLE: begin
                    if (clk_s2_q && dat_s2_q) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (fall) cnt_q <= '0;
                    else if (cnt_q == TO_LAST) begin
                        error_q <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else cnt_q <= cnt_d;
                end
                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx.tx_ready = ready_q;
    assign tx.busy     = busy_q;
    assign tx.done     = done_q;
    assign tx.error    = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on the open-drain bus, scoreboard of
// expected done/error outcomes and wire frames from a byte-level reference.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int REQ = 5;
    localparam int TO  = 400;
    localparam int H   = 20;

    logic clk = 1'b0;
    logic reset;
    logic ps2_clk_in, ps2_data_in, clk_oe, data_oe;
    logic dev_clk = 1'b0, dev_data = 1'b0;

    ps2_host_tx_if u_if ();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .TIMEOUT_CYCLES(TO)) dut (
        .CLK50(clk), .reset(reset), .tx(u_if),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe)
    );

    always #5 clk = ~clk;
    assign ps2_clk_in  = ~(clk_oe | dev_clk);
    assign ps2_data_in = ~(data_oe | dev_data);

    typedef struct {bit is_err; bit chk_frame; logic [10:0] frame;} exp_t;
    exp_t        sbq[$];
    logic [10:0] last_frame = '0;
    int          checks = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Wire frame in time order: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        int ones = $countones(d);
        return {1'b1, 1'((ones % 2) == 0), d, 1'b0};
    endfunction

    function automatic exp_t mk(input bit e, input bit c, input logic [7:0] d);
        exp_t x;
        x.is_err = e; x.chk_frame = c; x.frame = ref_frame(d);
        return x;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (u_if.done || u_if.error)) begin
                chk("done_and_error_together", {31'd0, u_if.done & u_if.error}, 32'd0);
                if (sbq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_pulse actual done=%0b error=%0b required none", u_if.done, u_if.error);
                end else begin
                    e = sbq.pop_front();
                    chk("outcome_is_error", {31'd0, u_if.error}, {31'd0, e.is_err});
                    chk("outcome_ready", {31'd0, u_if.tx_ready}, 32'd1);
                    if (e.chk_frame) chk("wire_frame", {21'd0, last_frame}, {21'd0, e.frame});
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d);
        int b = 0;
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = d;
        while (!u_if.tx_ready && b < 2000) begin @(negedge clk); b++; end
        chk("send_accept_wait", {31'd0, b < 2000}, 32'd1);
        @(negedge clk);
        u_if.tx_valid = 1'b0;
    endtask

    // mode 0: ack, 1: nack, 2: never clocks, 3: reset after fall 5. Call on a negedge.
    task automatic device(input int mode);
        int b = 0, hi = 0, dhi = 0, c = 0;
        logic [10:0] f = '0;
        while (!clk_oe && b < 2000) begin @(negedge clk); b++; end
        chk("dev_request_wait", {31'd0, b < 2000}, 32'd1);
        while (clk_oe && hi < 2000) begin
            hi++;
            if (data_oe) dhi++;
            @(negedge clk);
        end
        chk("clk_oe_high_cycles", hi, INH + REQ);
        chk("data_oe_req_cycles", dhi, REQ);
        if (mode == 2) begin
            while (!u_if.error && c < TO + 50) begin @(negedge clk); c++; end
            chk("timeout_cycles", c, TO);
            chk("timeout_oe", {30'd0, clk_oe, data_oe}, 32'd0);
            chk("timeout_ready", {31'd0, u_if.tx_ready}, 32'd1);
            return;
        end
        f[0] = ps2_data_in;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
            if (mode == 3 && k == 5) begin
                reset   = 1'b1;
                dev_clk = 1'b0;
                @(negedge clk);
                chk("abort_oe", {30'd0, clk_oe, data_oe}, 32'd0);
                chk("abort_ready", {31'd0, u_if.tx_ready}, 32'd1);
                reset = 1'b0;
                return;
            end
            dev_clk = 1'b0;
            repeat (H / 2) @(negedge clk);
            if (k <= 10) f[k] = ps2_data_in;
            if (k == 10) begin
                last_frame = f;
                if (mode == 0) dev_data = 1'b1;
            end
            repeat (H / 2) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        dev_data = 1'b0;
    endtask

    task automatic xfer_ack(input logic [7:0] d);
        sbq.push_back(mk(1'b0, 1'b1, d));
        fork
            send(d);
            device(0);
        join
        repeat (30) @(negedge clk);
    endtask

    initial begin
        int b;
        reset = 1'b1;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", {31'd0, clk_oe}, 32'd0);
        chk("rst_data_oe", {31'd0, data_oe}, 32'd0);
        chk("rst_ready", {31'd0, u_if.tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
        chk("rst_pulses", {30'd0, u_if.done, u_if.error}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        xfer_ack(8'hED);
        xfer_ack(8'hFF);
        repeat (4) xfer_ack(8'($urandom_range(0, 255)));

        sbq.push_back(mk(1'b1, 1'b0, 8'h3C));
        fork send(8'h3C); device(2); join
        repeat (30) @(negedge clk);

        sbq.push_back(mk(1'b1, 1'b1, 8'h00));
        fork send(8'h00); device(1); join
        repeat (30) @(negedge clk);

        fork send(8'h12); device(3); join
        repeat (30) @(negedge clk);
        xfer_ack(8'hF4);

        sbq.push_back(mk(1'b0, 1'b1, 8'hAA));
        sbq.push_back(mk(1'b0, 1'b1, 8'h55));
        fork
            begin
                int w = 0;
                u_if.tx_valid = 1'b1;
                u_if.tx_data  = 8'hAA;
                while (!clk_oe && w < 2000) begin @(negedge clk); w++; end
                while (clk_oe && w < 2000) begin @(negedge clk); w++; end
                chk("b2b_xfer_wait", {31'd0, w < 2000}, 32'd1);
                repeat (100) @(negedge clk);
                u_if.tx_data = 8'h55;
            end
            device(0);
        join
        b = 0;
        while (!u_if.done && b < 200) begin @(negedge clk); b++; end
        chk("b2b_done_seen", {31'd0, u_if.done}, 32'd1);
        chk("b2b_ready_with_done", {31'd0, u_if.tx_ready}, 32'd1);
        @(negedge clk);
        chk("b2b_restart_clk_oe", {31'd0, clk_oe}, 32'd1);
        chk("b2b_busy", {31'd0, u_if.busy}, 32'd1);
        u_if.tx_valid = 1'b0;
        device(0);
        repeat (50) @(negedge clk);

        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
